// File: rtl/seg_boot_loader.sv
// Multi-segment boot copier: walks a segment table, streams ROM bytes into the
// download port with back-pressure, then pulses execute_enable with the start vector.
module seg_boot_loader #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int NSEG    = 2,
  parameter int ROM_LAT = 1
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     start,
  input  logic [NSEG*ADDR_W-1:0]   seg_src,
  input  logic [NSEG*ADDR_W-1:0]   seg_dst,
  input  logic [NSEG*ADDR_W-1:0]   seg_len,
  input  logic [ADDR_W-1:0]        exec_vector,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [DATA_W-1:0]        rom_data,
  output logic                     dn_go,
  output logic                     dn_wr,
  output logic [ADDR_W-1:0]        dn_addr,
  output logic [DATA_W-1:0]        dn_data,
  input  logic                     dn_wait,
  output logic [ADDR_W-1:0]        execute_addr,
  output logic                     execute_enable,
  output logic                     busy,
  output logic [2:0]               seg_idx
);

  typedef enum logic [1:0] {IDLE, SETUP, FETCH, WRITE} state_t;

  // Index must reach NSEG itself (up to 8) to signal the end of the table.
  localparam int IDX_W = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSEG);
  localparam logic [1:0]       LAT      = 2'(ROM_LAT);

  state_t              state_q, state_d;
  logic                pending_q, pending_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   len_q, len_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [ADDR_W-1:0]   dn_addr_q, dn_addr_d;
  logic [DATA_W-1:0]   dn_data_q, dn_data_d;
  logic                dn_wr_q, dn_wr_d;
  logic                dn_go_q, dn_go_d;
  logic                busy_q, busy_d;
  logic [ADDR_W-1:0]   exec_addr_q, exec_addr_d;
  logic                exec_en_q, exec_en_d;

  logic [ADDR_W-1:0]   src_sel, dst_sel, len_sel;
  logic                accept;

  always_comb begin
    src_sel = '0;
    dst_sel = '0;
    len_sel = '0;
    for (int i = 0; i < NSEG; i++) begin
      if (idx_q == IDX_W'(i)) begin
        src_sel = seg_src[i*ADDR_W +: ADDR_W];
        dst_sel = seg_dst[i*ADDR_W +: ADDR_W];
        len_sel = seg_len[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign accept = dn_wr_q && !dn_wait;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= IDLE;
      pending_q   <= 1'b1;
      idx_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      rom_addr_q  <= '0;
      dn_addr_q   <= '0;
      dn_data_q   <= '0;
      dn_wr_q     <= 1'b0;
      dn_go_q     <= 1'b0;
      busy_q      <= 1'b0;
      exec_addr_q <= '0;
      exec_en_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      rom_addr_q  <= rom_addr_d;
      dn_addr_q   <= dn_addr_d;
      dn_data_q   <= dn_data_d;
      dn_wr_q     <= dn_wr_d;
      dn_go_q     <= dn_go_d;
      busy_q      <= busy_d;
      exec_addr_q <= exec_addr_d;
      exec_en_q   <= exec_en_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (pending_q || start) state_d = SETUP;
      SETUP: begin
        if (idx_q == LAST_IDX)   state_d = IDLE;
        else if (len_sel != '0)  state_d = FETCH;
      end
      FETCH: if (cnt_q == LAT) state_d = WRITE;
      WRITE: if (accept) state_d = (len_q == ADDR_W'(1)) ? SETUP : FETCH;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pending_d   = pending_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    rom_addr_d  = rom_addr_q;
    dn_addr_d   = dn_addr_q;
    dn_data_d   = dn_data_q;
    dn_wr_d     = dn_wr_q;
    dn_go_d     = dn_go_q;
    busy_d      = busy_q;
    exec_addr_d = exec_addr_q;
    exec_en_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pending_q || start) begin
          idx_d     = '0;
          dn_go_d   = 1'b1;
          busy_d    = 1'b1;
          pending_d = 1'b0;
        end
      end
      SETUP: begin
        if (idx_q == LAST_IDX) begin
          dn_go_d     = 1'b0;
          busy_d      = 1'b0;
          exec_addr_d = exec_vector;
          exec_en_d   = 1'b1;
        end else begin
          // Latch the table entry so later table edits cannot disturb this segment.
          len_d = len_sel;
          if (len_sel == '0) begin
            idx_d = idx_q + IDX_W'(1);
          end else begin
            rom_addr_d = src_sel;
            dn_addr_d  = dst_sel;
            cnt_d      = '0;
          end
        end
      end
      FETCH: begin
        if (cnt_q == LAT) begin
          dn_data_d = rom_data;
          dn_wr_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      WRITE: begin
        if (accept) begin
          dn_wr_d = 1'b0;
          len_d   = len_q - ADDR_W'(1);
          if (len_q == ADDR_W'(1)) begin
            idx_d = idx_q + IDX_W'(1);
          end else begin
            rom_addr_d = rom_addr_q + ADDR_W'(1);
            dn_addr_d  = dn_addr_q + ADDR_W'(1);
            cnt_d      = '0;
          end
        end
      end
      default: ;
    endcase
  end

  assign rom_addr       = rom_addr_q;
  assign dn_go          = dn_go_q;
  assign dn_wr          = dn_wr_q;
  assign dn_addr        = dn_addr_q;
  assign dn_data        = dn_data_q;
  assign execute_addr   = exec_addr_q;
  assign execute_enable = exec_en_q;
  assign busy           = busy_q;
  assign seg_idx        = idx_q[2:0];

endmodule

// File: tb/tb_seg_boot_loader.sv
// Scoreboard bench for seg_boot_loader: main instance (NSEG=3, ROM_LAT=1) plus
// two single-segment instances exercising ROM_LAT=0 and ROM_LAT=3 timing.
module tb_seg_boot_loader;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int NS = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic start = 1'b0;
  logic dn_wait = 1'b0;
  logic [NS*AW-1:0] seg_src, seg_dst, seg_len;
  logic [AW-1:0] exec_vector;

  logic [AW-1:0] m_rom_addr, m_dn_addr, m_exec_addr;
  logic [DW-1:0] m_rom_data, m_dn_data;
  logic m_go, m_wr, m_exec, m_busy;
  logic [2:0] m_idx;

  function automatic logic [7:0] rom_f(input logic [15:0] a);
    return a[7:0] ^ {a[3:0], a[15:12]} ^ 8'h3C;
  endfunction

  always @(posedge clk) m_rom_data <= rom_f(m_rom_addr);

  seg_boot_loader #(.ADDR_W(AW), .DATA_W(DW), .NSEG(NS), .ROM_LAT(1)) u_main (
    .clk_sys(clk), .reset(reset), .start(start),
    .seg_src(seg_src), .seg_dst(seg_dst), .seg_len(seg_len),
    .exec_vector(exec_vector), .rom_addr(m_rom_addr), .rom_data(m_rom_data),
    .dn_go(m_go), .dn_wr(m_wr), .dn_addr(m_dn_addr), .dn_data(m_dn_data),
    .dn_wait(dn_wait), .execute_addr(m_exec_addr), .execute_enable(m_exec),
    .busy(m_busy), .seg_idx(m_idx)
  );

  // Single-segment instances: src 0x30, dst 0x40, len 5.
  logic [AW-1:0] a0_rom_addr, a0_dn_addr, a0_exec_addr;
  logic [DW-1:0] a0_rom_data, a0_dn_data;
  logic a0_go, a0_wr, a0_exec, a0_busy;
  logic [2:0] a0_idx;
  assign a0_rom_data = rom_f(a0_rom_addr);

  seg_boot_loader #(.ADDR_W(AW), .DATA_W(DW), .NSEG(1), .ROM_LAT(0)) u_lat0 (
    .clk_sys(clk), .reset(reset), .start(1'b0),
    .seg_src(16'h0030), .seg_dst(16'h0040), .seg_len(16'd5),
    .exec_vector(16'hBEEF), .rom_addr(a0_rom_addr), .rom_data(a0_rom_data),
    .dn_go(a0_go), .dn_wr(a0_wr), .dn_addr(a0_dn_addr), .dn_data(a0_dn_data),
    .dn_wait(1'b0), .execute_addr(a0_exec_addr), .execute_enable(a0_exec),
    .busy(a0_busy), .seg_idx(a0_idx)
  );

  logic [AW-1:0] a3_rom_addr, a3_dn_addr, a3_exec_addr;
  logic [DW-1:0] a3_rom_data, a3_dn_data, a3_p1, a3_p2;
  logic a3_go, a3_wr, a3_exec, a3_busy;
  logic [2:0] a3_idx;
  always @(posedge clk) begin
    a3_p1       <= rom_f(a3_rom_addr);
    a3_p2       <= a3_p1;
    a3_rom_data <= a3_p2;
  end

  seg_boot_loader #(.ADDR_W(AW), .DATA_W(DW), .NSEG(1), .ROM_LAT(3)) u_lat3 (
    .clk_sys(clk), .reset(reset), .start(1'b0),
    .seg_src(16'h0030), .seg_dst(16'h0040), .seg_len(16'd5),
    .exec_vector(16'hCAFE), .rom_addr(a3_rom_addr), .rom_data(a3_rom_data),
    .dn_go(a3_go), .dn_wr(a3_wr), .dn_addr(a3_dn_addr), .dn_data(a3_dn_data),
    .dn_wait(1'b0), .execute_addr(a3_exec_addr), .execute_enable(a3_exec),
    .busy(a3_busy), .seg_idx(a3_idx)
  );

  // Edge index: 0 = first edge with reset low.
  int ecnt = 0;
  always @(posedge clk) begin
    if (reset) ecnt <= 0;
    else       ecnt <= ecnt + 1;
  end

  int nchk = 0;
  int nerr = 0;
  logic [AW+DW-1:0] wq[$];
  int               eq_edge[$];
  logic [AW-1:0]    eq_addr[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    nchk++;
    nerr++;
    $display("FAIL %s: got %0h expected none", name, act);
  endtask

  task automatic push_seg(input logic [15:0] src, input logic [15:0] dst, input int len);
    logic [15:0] s, d;
    s = src;
    d = dst;
    for (int k = 0; k < len; k++) begin
      wq.push_back({d, rom_f(s)});
      s = s + 16'd1;
      d = d + 16'd1;
    end
  endtask

  task automatic push_exec(input int e, input logic [15:0] a);
    eq_edge.push_back(e);
    eq_addr.push_back(a);
  endtask

  task automatic set_seg(input int i, input logic [15:0] s, input logic [15:0] d,
                         input logic [15:0] l);
    seg_src[i*AW +: AW] = s;
    seg_dst[i*AW +: AW] = d;
    seg_len[i*AW +: AW] = l;
  endtask

  task automatic wait_wr(input logic [15:0] addr, input int budget);
    int n;
    n = 0;
    while (!(m_wr && m_dn_addr == addr) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (!(m_wr && m_dn_addr == addr)) fail_now("wait_wr_timeout", {16'h0, addr});
  endtask

  task automatic wait_exec(input int budget);
    int n;
    n = 0;
    while (!m_exec && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (!m_exec) fail_now("wait_exec_timeout", n);
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Main monitor: pops expected writes/exec events whenever the DUT presents them.
  logic hold_p = 1'b0;
  logic exec_p = 1'b0;
  logic [AW-1:0] hold_addr, hold_rom;
  logic [DW-1:0] hold_data;
  initial begin
    logic [AW+DW-1:0] e;
    int ee;
    logic [AW-1:0] ea;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold_p = 1'b0;
        exec_p = 1'b0;
      end else begin
        if (hold_p) begin
          chk("hold_wr", m_wr, 1);
          chk("hold_addr", m_dn_addr, hold_addr);
          chk("hold_data", m_dn_data, hold_data);
          chk("hold_rom_addr", m_rom_addr, hold_rom);
        end
        if (m_wr && !dn_wait) begin
          if (wq.size() == 0) begin
            fail_now("unexpected_write", {8'h0, m_dn_addr, m_dn_data});
          end else begin
            e = wq.pop_front();
            chk("wr_addr", m_dn_addr, e[AW+DW-1:DW]);
            chk("wr_data", m_dn_data, e[DW-1:0]);
          end
          chk("go_busy_in_copy", {m_go, m_busy}, 2'b11);
        end
        if (exec_p) chk("exec_single_cycle", m_exec, 0);
        if (m_exec) begin
          if (eq_edge.size() == 0) begin
            fail_now("unexpected_exec", m_exec_addr);
          end else begin
            ee = eq_edge.pop_front();
            ea = eq_addr.pop_front();
            chk("exec_edge", ecnt - 1, ee);
            chk("exec_addr", m_exec_addr, ea);
            chk("exec_go_busy", {m_go, m_busy}, 2'b00);
            chk("exec_seg_idx", m_idx, NS);
          end
        end
        hold_p    = m_wr && dn_wait;
        hold_addr = m_dn_addr;
        hold_data = m_dn_data;
        hold_rom  = m_rom_addr;
        exec_p    = m_exec;
      end
    end
  end

  // Latency-variant monitors: 5 bytes, completion at edge 5*(ROM_LAT+2)+2.
  int a0_cnt = 0, a3_cnt = 0, a0_runs = 0, a3_runs = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        a0_cnt = 0;
        a3_cnt = 0;
      end else begin
        if (a0_wr) begin
          chk("lat0_data", a0_dn_data, rom_f(16'h0030 + (a0_dn_addr - 16'h0040)));
          a0_cnt++;
        end
        if (a0_exec) begin
          chk("lat0_exec_edge", ecnt - 1, 12);
          chk("lat0_exec_addr", a0_exec_addr, 16'hBEEF);
          chk("lat0_count", a0_cnt, 5);
          a0_cnt = 0;
          a0_runs++;
        end
        if (a3_wr) begin
          chk("lat3_data", a3_dn_data, rom_f(16'h0030 + (a3_dn_addr - 16'h0040)));
          a3_cnt++;
        end
        if (a3_exec) begin
          chk("lat3_exec_edge", ecnt - 1, 27);
          chk("lat3_exec_addr", a3_exec_addr, 16'hCAFE);
          chk("lat3_count", a3_cnt, 5);
          a3_cnt = 0;
          a3_runs++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    set_seg(0, 16'h0000, 16'h0000, 16'd276);
    set_seg(1, 16'h0010, 16'h0200, 16'd0);
    set_seg(2, 16'h0020, 16'h0300, 16'd0);
    exec_vector = 16'h1234;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rom_addr", m_rom_addr, 0);
    chk("rst_dn_addr", m_dn_addr, 0);
    chk("rst_dn_data", m_dn_data, 0);
    chk("rst_exec_addr", m_exec_addr, 0);
    chk("rst_seg_idx", m_idx, 0);
    chk("rst_ctrl", {m_go, m_wr, m_busy, m_exec}, 0);

    // Power-on copy, interrupted by reset (with start) while byte 100 is presented
    push_seg(16'h0000, 16'h0000, 100);
    @(posedge clk); #1;
    reset = 1'b0;
    wait_wr(16'd100, 2000);
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("midrst_ctrl", {m_go, m_wr, m_busy, m_exec}, 0);
    chk("midrst_addrs", {m_rom_addr, m_dn_addr}, 0);
    chk("midrst_seg_idx", m_idx, 0);
    chk("midrst_writes_seen", wq.size(), 0);

    // Restart from segment 0 after deassertion
    push_seg(16'h0000, 16'h0000, 276);
    push_exec(NS + 276 * 3 + 1, 16'h1234);
    @(posedge clk); #1;
    reset = 1'b0;
    wait_wr(16'd50, 2000);
    pulse_start();
    wait_exec(3000);

    // Re-run by start, with 5 wait cycles on byte 3
    base = ecnt;
    push_seg(16'h0000, 16'h0000, 276);
    push_exec(base + NS + 276 * 3 + 1 + 5, 16'h1234);
    pulse_start();
    wait_wr(16'd3, 100);
    dn_wait = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    dn_wait = 1'b0;
    wait_exec(3000);

    // Three segments, middle one skipped; seg0 edited after it was sampled
    set_seg(0, 16'h0050, 16'h0100, 16'd4);
    set_seg(1, 16'h0060, 16'h0200, 16'd0);
    set_seg(2, 16'h0070, 16'h0300, 16'd2);
    exec_vector = 16'hA5A5;
    base = ecnt;
    push_seg(16'h0050, 16'h0100, 4);
    push_seg(16'h0070, 16'h0300, 2);
    push_exec(base + NS + 6 * 3 + 1, 16'hA5A5);
    pulse_start();
    repeat (3) @(posedge clk);
    #1;
    set_seg(0, 16'h0900, 16'h0700, 16'd9);
    wait_exec(200);

    // Address wrap on both ROM and destination side
    set_seg(0, 16'hFFFD, 16'hFFFE, 16'd4);
    set_seg(1, 16'h0010, 16'h0500, 16'd1);
    set_seg(2, 16'h0020, 16'h0600, 16'd0);
    exec_vector = 16'h0F0F;
    base = ecnt;
    push_seg(16'hFFFD, 16'hFFFE, 4);
    push_seg(16'h0010, 16'h0500, 1);
    push_exec(base + NS + 5 * 3 + 1, 16'h0F0F);
    pulse_start();
    wait_exec(200);

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("idle_ctrl", {m_go, m_wr, m_busy, m_exec}, 0);
    chk("writes_left", wq.size(), 0);
    chk("exec_left", eq_edge.size(), 0);
    chk("lat0_runs", a0_runs, 2);
    chk("lat3_runs", a3_runs, 2);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/seg_boot_loader.md
# seg_boot_loader

Parametrised multi-segment boot loader sitting between the on-chip boot ROM and the pcw_core download port (dn_go/dn_wr/dn_addr/dn_data). After every reset, and on request, it copies NSEG ROM segments to independent destination addresses, honours download back-pressure, then pulses execute_enable with the start vector. It generalises the single fixed-length post-reset copy to a segment table, configurable ROM latency, wait handshake and software re-trigger.

## Interface
- ADDR_W, 16, address/length width for ROM and download side
- DATA_W, 8, data width
- NSEG, 2, number of segments in table (1..8)
- ROM_LAT, 1, ROM read latency in clocks (0 = combinational ROM, max 3)

- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle re-run request, honoured only in IDLE
- seg_src  in  NSEG*ADDR_W  per-segment ROM base, segment i at bits [i*ADDR_W +: ADDR_W]
- seg_dst  in  NSEG*ADDR_W  per-segment destination base
- seg_len  in  NSEG*ADDR_W  per-segment byte count, 0 = skip
- exec_vector  in  ADDR_W  start address presented on completion
- rom_addr  out  ADDR_W  registered ROM address
- rom_data  in  DATA_W  ROM data
- dn_go  out  1  high for whole copy
- dn_wr  out  1  write strobe, held while dn_wait
- dn_addr  out  ADDR_W  write address
- dn_data  out  DATA_W  write data
- dn_wait  in  1  back-pressure; write accepted on an edge with dn_wr=1, dn_wait=0
- execute_addr  out  ADDR_W  exec_vector latched at completion
- execute_enable  out  1  one-cycle completion pulse
- busy  out  1  high from SETUP entry until completion
- seg_idx  out  3  current segment index

## Operation
- States: IDLE, SETUP, FETCH, WRITE.
- While reset=1: state IDLE, pending flag set, every output 0 (rom_addr, dn_addr, dn_data, execute_addr, seg_idx included).
- IDLE: if pending or start -> SETUP, seg_idx<=0, dn_go<=1, busy<=1, pending<=0. start while busy ignored, not queued.
- SETUP (seg_idx<NSEG): sample seg_src/dst/len[seg_idx] into working registers; len=0 -> seg_idx++, stay SETUP; else rom_addr<=src, dn_addr<=dst, -> FETCH. Table changes after sampling do not affect the current segment.
- SETUP (seg_idx==NSEG): dn_go<=0, busy<=0, execute_addr<=exec_vector, execute_enable<=1, -> IDLE.
- FETCH: counter runs ROM_LAT+1 cycles; on last cycle dn_data<=rom_data, dn_wr<=1, -> WRITE.
- WRITE: dn_wait=1 -> hold dn_wr, dn_addr, dn_data, rom_addr unchanged. Accept -> dn_wr<=0, len--; len now 0 -> seg_idx++, -> SETUP; else rom_addr++, dn_addr++ (with the same edge), -> FETCH.
- Address arithmetic modulo 2^ADDR_W: src and dst wrap FFFF->0000 silently. Max segment length 2^ADDR_W-1.
- execute_enable cleared the cycle after it is set, in every state.

## Timing
- Edge 0 = first clock edge with reset=0: IDLE->SETUP, dn_go=1, busy=1.
- Edge 1: SETUP->FETCH, rom_addr=src0, dn_addr=dst0.
- Per byte: ROM_LAT+2 cycles without wait; each wait cycle adds one.
- Byte k of first segment, no wait: dn_wr rises at edge 1+(k+1)(ROM_LAT+2)-1, accepted next edge.
- Each SETUP visit (incl. skipped segment and final) costs 1 cycle.
- NSEG=1, len N, no wait: execute_enable high after edge (ROM_LAT+2)N+2, low after next edge; dn_go and busy fall on the same edge execute_enable rises.
- Reset mid-copy: all outputs 0 on the reset edge, no execute pulse; full copy restarts from segment 0 at edge 0 after deassertion.
- reset and start same cycle: reset wins; copy still runs after deassert (pending).

## Test plan
- NSEG=1, ROM_LAT=1, src 0, dst 0, len 276, dn_wait=0 -> 276 dn_wr pulses, dn_addr 0..275, dn_data = ROM[addr]; execute_enable single pulse after edge 830, execute_addr=exec_vector.
- dn_wait held high 5 cycles during byte 3 -> dn_wr high 6 cycles with dn_addr=3 and data stable; completion 5 cycles later; no duplicate or lost byte.
- NSEG=3, lens 4,0,2, dst 0x100/0x200/0x300 -> writes 0x100..0x103, 0x300..0x301, none at 0x200; one extra cycle for skipped SETUP.
- dst 0xFFFE, len 4 -> dn_addr FFFE, FFFF, 0000, 0001.
- reset pulsed at byte 100 -> dn_go/dn_wr/busy 0 on reset edge, no execute pulse; restart writes from dst0 byte 0; exactly one execute pulse overall.
- start pulse while busy -> ignored; start in IDLE -> identical second copy and second execute pulse; ROM_LAT=0 and 3 runs -> 2 and 5 cycles per byte.
